// File: rtl/rom_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous ROM.
// One read is in flight at a time: IDLE/RETURN arbitrate, ISSUE drives the ROM, WAIT covers its latency.
module rom_arbiter #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              busy,
    output logic [ADDR_W-1:0] ROM_addr,
    output logic              ROM_re,
    output logic              ROM_ce,
    input  logic [DATA_W-1:0] ROM_data
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RETURN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              last;       // requester served most recently
    logic              last_nxt;
    logic              win;        // requester owning the current transaction
    logic              win_nxt;
    logic              arb_win;

    logic              gnt0_nxt;
    logic              gnt1_nxt;
    logic              rvalid0_nxt;
    logic              rvalid1_nxt;
    logic              busy_nxt;
    logic              ce_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] rdata0_nxt;
    logic [DATA_W-1:0] rdata1_nxt;

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            last     <= 1'b1;
            win      <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            busy     <= 1'b0;
            ROM_ce   <= 1'b0;
            ROM_re   <= 1'b0;
            ROM_addr <= '0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            last     <= last_nxt;
            win      <= win_nxt;
            gnt0     <= gnt0_nxt;
            gnt1     <= gnt1_nxt;
            rvalid0  <= rvalid0_nxt;
            rvalid1  <= rvalid1_nxt;
            busy     <= busy_nxt;
            ROM_ce   <= ce_nxt;
            ROM_re   <= ce_nxt;
            ROM_addr <= addr_nxt;
            rdata0   <= rdata0_nxt;
            rdata1   <= rdata1_nxt;
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        last_nxt    = last;
        win_nxt     = win;
        gnt0_nxt    = 1'b0;
        gnt1_nxt    = 1'b0;
        rvalid0_nxt = 1'b0;
        rvalid1_nxt = 1'b0;
        ce_nxt      = 1'b0;
        addr_nxt    = '0;
        rdata0_nxt  = rdata0;
        rdata1_nxt  = rdata1;
        // On a tie the requester not served last wins; otherwise the sole requester
        arb_win     = (req0 && req1) ? ~last : req1;

        case (state)
            IDLE, RETURN: begin
                if (req0 || req1) begin
                    state_nxt = ISSUE;
                    win_nxt   = arb_win;
                    last_nxt  = arb_win;
                    gnt0_nxt  = ~arb_win;
                    gnt1_nxt  = arb_win;
                    ce_nxt    = 1'b1;
                    addr_nxt  = arb_win ? addr1 : addr0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
                cnt_nxt   = '0;
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = RETURN;
                    cnt_nxt   = '0;
                    if (win) begin
                        rdata1_nxt  = ROM_data;
                        rvalid1_nxt = 1'b1;
                    end else begin
                        rdata0_nxt  = ROM_data;
                        rvalid0_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: two instances (ROM_LAT 1 and 3) share stimulus and are checked
// every cycle against a transaction-schedule model, plus literal expectations.
module tb_rom_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [3:0] addr0 = 4'h0;
    logic [3:0] addr1 = 4'h0;

    logic [1:0] g0, g1, rv0, rv1, bsy, ce, re;
    logic [3:0] raddr [2];
    logic [7:0] rd0 [2];
    logic [7:0] rd1 [2];
    logic [7:0] romd [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rom_arbiter #(.ADDR_W(4), .DATA_W(8), .ROM_LAT(1)) dut_l1 (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .gnt0(g0[0]), .gnt1(g1[0]), .rdata0(rd0[0]), .rdata1(rd1[0]),
        .rvalid0(rv0[0]), .rvalid1(rv1[0]), .busy(bsy[0]),
        .ROM_addr(raddr[0]), .ROM_re(re[0]), .ROM_ce(ce[0]), .ROM_data(romd[0])
    );

    rom_arbiter #(.ADDR_W(4), .DATA_W(8), .ROM_LAT(3)) dut_l3 (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .gnt0(g0[1]), .gnt1(g1[1]), .rdata0(rd0[1]), .rdata1(rd1[1]),
        .rvalid0(rv0[1]), .rvalid1(rv1[1]), .busy(bsy[1]),
        .ROM_addr(raddr[1]), .ROM_re(re[1]), .ROM_ce(ce[1]), .ROM_data(romd[1])
    );

    // ROM models: data = {addr, ~addr}, ROM_LAT register stages after the sampling edge
    logic [7:0] p1;
    logic [7:0] p3 [3];
    always @(posedge clk) p1 <= (ce[0] && re[0]) ? {raddr[0], ~raddr[0]} : 8'h00;
    always @(posedge clk) begin
        p3[0] <= (ce[1] && re[1]) ? {raddr[1], ~raddr[1]} : 8'h00;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign romd[0] = p1;
    assign romd[1] = p3[2];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (ROM_LAT=%0d) at t=%0t: got %h, expected %h", name, lat_of(k), $time, act, exp);
        end
    endtask

    // Schedule model: an arbitration at edge n grants in cycle n, returns in cycle n+LAT+1,
    // and the next arbitration may happen at edge n+LAT+2.
    int         n = 0;
    int         gc [2] = '{-1, -1};
    int         rc [2] = '{-1, -1};
    int         na [2] = '{0, 0};
    bit         mw [2] = '{1'b0, 1'b0};
    bit         ml [2] = '{1'b1, 1'b1};
    logic [3:0] ma [2] = '{4'h0, 4'h0};
    logic [7:0] m0 [2] = '{8'h00, 8'h00};
    logic [7:0] m1 [2] = '{8'h00, 8'h00};

    always @(posedge clk) begin
        n = n + 1;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                gc[k] = -1; rc[k] = -1; na[k] = 0; ml[k] = 1'b1;
                m0[k] = 8'h00; m1[k] = 8'h00;
            end else begin
                if (n == rc[k]) begin
                    if (mw[k]) m1[k] = {ma[k], ~ma[k]};
                    else       m0[k] = {ma[k], ~ma[k]};
                end
                if (n >= na[k] && (req0 || req1)) begin
                    mw[k] = (req0 && req1) ? !ml[k] : req1;
                    ml[k] = mw[k];
                    ma[k] = mw[k] ? addr1 : addr0;
                    gc[k] = n;
                    rc[k] = n + lat_of(k) + 1;
                    na[k] = n + lat_of(k) + 2;
                end
            end
        end
    end

    logic       e_g, e_v, e_b;
    logic [3:0] e_a;

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            e_g = !reset && (n == gc[k]);
            e_v = !reset && (n == rc[k]);
            e_b = !reset && (gc[k] >= 0) && (n >= gc[k]) && (n <= rc[k]);
            e_a = e_g ? ma[k] : 4'h0;
            check("gnt0",   k, 32'(g0[k]),    32'(e_g && !mw[k]));
            check("gnt1",   k, 32'(g1[k]),    32'(e_g && mw[k]));
            check("rvalid0",k, 32'(rv0[k]),   32'(e_v && !mw[k]));
            check("rvalid1",k, 32'(rv1[k]),   32'(e_v && mw[k]));
            check("busy",   k, 32'(bsy[k]),   32'(e_b));
            check("rom_ce", k, 32'(ce[k]),    32'(e_g));
            check("rom_re", k, 32'(re[k]),    32'(e_g));
            check("rom_addr",k, 32'(raddr[k]), 32'(e_a));
            check("rdata0", k, 32'(rd0[k]),   reset ? 32'h0 : 32'(m0[k]));
            check("rdata1", k, 32'(rd1[k]),   reset ? 32'h0 : 32'(m1[k]));
        end
    end

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    initial begin
        // reset state
        tick(2);
        reset = 1'b0;
        check("lit_reset_busy",   0, 32'(bsy),    32'h0);
        check("lit_reset_rdata0", 0, 32'(rd0[0]), 32'h0);

        // single read, addr 5
        req0 = 1'b1; addr0 = 4'h5;
        tick(1);
        check("lit_single_gnt0",  0, 32'(g0[0]),    32'h1);
        check("lit_single_ce",    0, 32'(ce[0]),    32'h1);
        check("lit_single_addr",  0, 32'(raddr[0]), 32'h5);
        check("lit_single_gnt0",  1, 32'(g0[1]),    32'h1);
        req0 = 1'b0;
        tick(2);
        check("lit_single_rvalid0", 0, 32'(rv0[0]), 32'h1);
        check("lit_single_rdata0",  0, 32'(rd0[0]), 32'h5A);
        check("lit_single_rdata1",  0, 32'(rd1[0]), 32'h00);
        tick(1);
        check("lit_single_rvalid_pulse", 0, 32'(rv0[0]), 32'h0);
        tick(1);
        check("lit_lat3_rvalid0", 1, 32'(rv0[1]), 32'h1);
        check("lit_lat3_rdata0",  1, 32'(rd0[1]), 32'h5A);
        tick(4);

        // tie from reset, then alternation
        reset = 1'b1;
        req0 = 1'b1; addr0 = 4'h3; req1 = 1'b1; addr1 = 4'hC;
        tick(1);
        reset = 1'b0;
        tick(1);
        check("lit_tie_gnt0", 0, 32'(g0[0]), 32'h1);
        check("lit_tie_gnt1", 0, 32'(g1[0]), 32'h0);
        check("lit_tie_gnt0", 1, 32'(g0[1]), 32'h1);
        tick(2);
        check("lit_tie_rdata0", 0, 32'(rd0[0]), 32'h3C);
        tick(1);
        check("lit_tie_gnt1_next", 0, 32'(g1[0]), 32'h1);
        tick(2);
        check("lit_tie_rvalid1", 0, 32'(rv1[0]), 32'h1);
        check("lit_tie_rdata1",  0, 32'(rd1[0]), 32'hC3);
        check("lit_tie_gnt1",    1, 32'(g1[1]),  32'h1);
        tick(1);
        check("lit_tie_alt_gnt0", 0, 32'(g0[0]), 32'h1);
        req0 = 1'b0; req1 = 1'b0;
        tick(8);

        // back-to-back on requester 1
        req1 = 1'b1; addr1 = 4'h0;
        tick(1);
        check("lit_b2b_gnt1_a", 0, 32'(g1[0]), 32'h1);
        addr1 = 4'h1;
        tick(2);
        check("lit_b2b_rdata1_a", 0, 32'(rd1[0]), 32'h0F);
        tick(1);
        check("lit_b2b_gnt1_b", 0, 32'(g1[0]), 32'h1);
        addr1 = 4'h2;
        tick(2);
        check("lit_b2b_rdata1_b", 0, 32'(rd1[0]), 32'h1E);
        tick(1);
        check("lit_b2b_gnt1_c", 0, 32'(g1[0]), 32'h1);
        req1 = 1'b0;
        tick(2);
        check("lit_b2b_rdata1_c", 0, 32'(rd1[0]), 32'h2D);
        tick(6);

        // withdrawn request pulse during another transaction
        req0 = 1'b1; addr0 = 4'h7;
        tick(1);
        req0 = 1'b0; req1 = 1'b1; addr1 = 4'h9;
        tick(1);
        req1 = 1'b0;
        tick(1);
        check("lit_wd_rdata0", 0, 32'(rd0[0]), 32'h78);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("lit_wd_no_gnt1", 0, 32'(g1), 32'h0);
        end

        // reset during WAIT discards the read
        req0 = 1'b1; addr0 = 4'h9;
        tick(1);
        req0 = 1'b0;
        tick(1);
        reset = 1'b1;
        #1;
        check("lit_rst_busy",   0, 32'(bsy),    32'h0);
        check("lit_rst_rdata0", 0, 32'(rd0[0]), 32'h0);
        req0 = 1'b1; addr0 = 4'hF;
        tick(1);
        reset = 1'b0;
        tick(1);
        check("lit_rst_gnt0", 0, 32'(g0[0]),    32'h1);
        check("lit_rst_addr", 0, 32'(raddr[0]), 32'hF);
        req0 = 1'b0;
        tick(2);
        check("lit_rst_rvalid0", 0, 32'(rv0[0]), 32'h1);
        check("lit_rst_rdata0",  0, 32'(rd0[0]), 32'hF0);
        tick(2);
        check("lit_rst_rdata0", 1, 32'(rd0[1]), 32'hF0);
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
